// File: rtl/memory_port.sv
// memory_port
// Single-outstanding memory access unit sitting between the multi-cycle core
// controller and the system bus. One fetch/load/store is accepted at a time,
// driven onto the bus with a request/grant/response handshake guarded by a
// timeout, and completed with a one-cycle memory_valid pulse.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   memory_enable         : controller request strobe (taken only when ready)
//   memory_command        : 0 = read, 1 = write
//   address, write_data   : byte address and LSB-justified store data
//   access_type           : funct3 size/sign code (B,H,W,BU,HU)
//   memory_ready          : idle, can accept a request
//   memory_valid          : one-cycle completion pulse
//   read_data             : aligned, extended load data
//   misaligned_exception  : combinational misalignment flag
//   access_fault          : completion carries a bus error or timeout
//   bus_request/bus_write/bus_address/bus_write_data/bus_byte_enable : bus request side
//   bus_grant/bus_response_valid/bus_read_data/bus_error            : bus response side
module memory_port #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memory_enable,
    input  logic        memory_command,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [2:0]  access_type,
    output logic        memory_ready,
    output logic        memory_valid,
    output logic [31:0] read_data,
    output logic        misaligned_exception,
    output logic        access_fault,
    output logic        bus_request,
    output logic        bus_write,
    output logic [31:0] bus_address,
    output logic [31:0] bus_write_data,
    output logic [3:0]  bus_byte_enable,
    input  logic        bus_grant,
    input  logic        bus_response_valid,
    input  logic [31:0] bus_read_data,
    input  logic        bus_error
);

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        WAIT,
        RESPOND
    } state_t;

    localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT_CYCLES);

    state_t      state;
    logic [15:0] count;
    logic [2:0]  type_q;
    logic [1:0]  offset_q;
    logic [16:0] count_inc;
    logic        timeout_hit;

    // Replicate the store operand across lanes so the slave can pick any lane.
    function automatic logic [31:0] encode_data(input logic [1:0] size,
                                                input logic [31:0] data);
        case (size)
            2'b00:   return {4{data[7:0]}};
            2'b01:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [3:0] encode_be(input logic [1:0] size,
                                             input logic [1:0] offset);
        case (size)
            2'b00:   return 4'b0001 << offset;
            2'b01:   return 4'b0011 << {offset[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] decode_read(input logic [2:0] kind,
                                                input logic [1:0] offset,
                                                input logic [31:0] word);
        logic [31:0] shifted;
        shifted = word >> {offset, 3'b000};
        case (kind)
            3'b000:  return {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  return {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  return {24'd0, shifted[7:0]};
            3'b101:  return {16'd0, shifted[15:0]};
            default: return shifted;
        endcase
    endfunction

    // Size codes 10 and 11 are both treated as word-sized for alignment.
    always_comb begin
        misaligned_exception = 1'b0;
        if (access_type[1])
            misaligned_exception = (address[1:0] != 2'b00);
        else if (access_type[0])
            misaligned_exception = address[0];
    end

    // The counter value seen in a cycle is the number of earlier
    // REQUEST/WAIT cycles, so +1 is the count including this one.
    assign count_inc   = {1'b0, count} + 17'd1;
    assign timeout_hit = (count_inc == TIMEOUT_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            memory_ready    <= 1'b1;
            memory_valid    <= 1'b0;
            access_fault    <= 1'b0;
            read_data       <= 32'd0;
            bus_request     <= 1'b0;
            bus_write       <= 1'b0;
            bus_byte_enable <= 4'b0000;
            count           <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    memory_valid <= 1'b0;
                    if (memory_enable && !misaligned_exception) begin
                        bus_address     <= {address[31:2], 2'b00};
                        bus_write       <= memory_command;
                        bus_write_data  <= encode_data(access_type[1:0], write_data);
                        bus_byte_enable <= memory_command
                                           ? encode_be(access_type[1:0], address[1:0])
                                           : 4'b1111;
                        type_q          <= access_type;
                        offset_q        <= address[1:0];
                        count           <= 16'd0;
                        memory_ready    <= 1'b0;
                        bus_request     <= 1'b1;
                        state           <= REQUEST;
                    end
                end
                REQUEST: begin
                    count <= count + 16'd1;
                    if (timeout_hit) begin
                        bus_request  <= 1'b0;
                        access_fault <= 1'b1;
                        read_data    <= 32'd0;
                        memory_valid <= 1'b1;
                        state        <= RESPOND;
                    end else if (bus_grant) begin
                        bus_request <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    count <= count + 16'd1;
                    // A response in the timeout cycle takes priority.
                    if (bus_response_valid) begin
                        read_data    <= bus_error ? 32'd0
                                        : decode_read(type_q, offset_q, bus_read_data);
                        access_fault <= bus_error;
                        memory_valid <= 1'b1;
                        state        <= RESPOND;
                    end else if (timeout_hit) begin
                        access_fault <= 1'b1;
                        read_data    <= 32'd0;
                        memory_valid <= 1'b1;
                        state        <= RESPOND;
                    end
                end
                RESPOND: begin
                    memory_valid <= 1'b0;
                    memory_ready <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    state        <= IDLE;
                    memory_ready <= 1'b1;
                    memory_valid <= 1'b0;
                    bus_request  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/memory_port.md
# memory_port

Single-outstanding memory access unit between the multi-cycle core controller and the system bus. It accepts one fetch, load or store request from the controller and flags misaligned addresses. It encodes store data into byte lanes, runs a request/grant/response handshake on the bus with a timeout, and returns aligned, sign- or zero-extended read data. It drives the controller's `memory_ready`, `memory_valid` and `misaligned_exception` inputs.

## Interface
- `TIMEOUT_CYCLES`, 255: cycles in REQUEST+WAIT before the access is aborted with a fault (1..65535).

- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `memory_enable` in 1: controller request strobe; accepted only when `memory_ready`=1.
- `memory_command` in 1: 0 = read (fetch/load), 1 = write (store).
- `address` in 32: byte address.
- `write_data` in 32: store data, LSB-justified.
- `access_type` in 3: funct3 encoding. 000 B, 001 H, 010 W, 100 BU, 101 HU. Writes use [1:0]; fetch drives 010.
- `memory_ready` out 1: idle, can accept.
- `memory_valid` out 1: one-cycle completion pulse.
- `read_data` out 32: extended load data, valid while `memory_valid`=1.
- `misaligned_exception` out 1: combinational misalignment flag of `address`/`access_type`.
- `access_fault` out 1: qualifies `memory_valid`; bus error or timeout.
- `bus_request` out 1: request to bus.
- `bus_write` out 1: request is a write.
- `bus_address` out 32: word address, `{address[31:2],2'b00}`.
- `bus_write_data` out 32: lane-encoded store data.
- `bus_byte_enable` out 4: active lanes; 1111 for reads.
- `bus_grant` in 1: bus accepted the request this cycle.
- `bus_response_valid` in 1: response present this cycle.
- `bus_read_data` in 32: full read word.
- `bus_error` in 1: response is an error, qualified by `bus_response_valid`.

## Operation
- States: IDLE, REQUEST, WAIT, RESPOND.
- `misaligned_exception` is combinational and ignores `memory_enable`. It is 1 when:
  - size H and `address[0]`=1, or
  - size W and `address[1:0]`≠0.
- IDLE:
  - `memory_ready`=1.
  - On `memory_enable`=1 with no misalignment, latch `address`, `memory_command`, `access_type` and the encoded write data and byte enable, then go to REQUEST.
  - Misaligned requests are dropped: state stays IDLE, no bus activity.
- Store encoding:
  - B: byte replicated to all lanes, BE = 0001<<`address[1:0]`.
  - H: halfword replicated, BE = 0011<<(2·`address[1]`).
  - W: data as is, BE = 1111.
- REQUEST:
  - `bus_request`=1; the bus outputs hold their latched values.
  - Go to WAIT on `bus_grant`.
  - A response is never accepted in the grant cycle.
- WAIT:
  - On `bus_response_valid`, capture decoded data and the error flag, then go to RESPOND.
- Read decode:
  - Shift `bus_read_data` right by 8·`address[1:0]`.
  - B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through.
  - On error, `read_data` is 0.
- Timeout:
  - A 16-bit counter clears on accept and increments each cycle in REQUEST or WAIT.
  - When it reaches `TIMEOUT_CYCLES` with no response that cycle, drop `bus_request` and go to RESPOND with `access_fault`=1 and `read_data`=0.
  - A response arriving in the same cycle as the timeout wins.
- RESPOND:
  - `memory_valid`=1 for exactly one cycle.
  - `read_data` and `access_fault` are registered.
  - Next state is IDLE.
- `bus_response_valid` outside WAIT is ignored, including late responses after a timeout.

## Timing
- Reset state is IDLE. After reset: `memory_ready`=1, `memory_valid`=0, `access_fault`=0, `read_data`=0, `bus_request`=0, `bus_byte_enable`=0000, counter 0.
- A reset in any state returns to IDLE on the next edge. `bus_request` is then 0 and any in-flight response is discarded.
- Minimum latency, with grant and response each arriving on their first eligible cycle:
  - Accept at cycle 0.
  - REQUEST with grant at cycle 1.
  - WAIT with response at cycle 2.
  - `memory_valid` at cycle 3.
  - `memory_ready` returns at cycle 4.
- `memory_ready` is 0 from the cycle after accept through RESPOND. Only one access is ever outstanding.
- Outputs depending only on state are glitch-free registered decodes. The only combinational input-to-output path is `misaligned_exception`.

## Test plan
- LW at 0x100, grant at cycle 1, response 0xDEADBEEF at cycle 2 -> `memory_valid` at cycle 3, `read_data`=0xDEADBEEF, `access_fault`=0, `bus_address`=0x100, BE=1111.
- LB at 0x103 with bus word 0x80112233 -> `read_data`=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x102 -> 0x00008011.
- SB 0x000000A5 at 0x202 -> `bus_write`=1, `bus_address`=0x200, `bus_write_data`=0xA5A5A5A5, BE=0100. SH 0x1234 at 0x202 -> 0x12341234, BE=1100.
- LW at 0x101 with `memory_enable`=1 -> `misaligned_exception`=1, `bus_request` stays 0, `memory_ready` stays 1.
- With `TIMEOUT_CYCLES`=8 and the grant never given -> `bus_request` is high for 8 cycles, then `memory_valid`=1 with `access_fault`=1 and `read_data`=0. A late response 3 cycles after that has no effect.
- Reset asserted in WAIT -> next cycle: IDLE, `bus_request`=0, `memory_ready`=1. A subsequent `bus_response_valid` produces no `memory_valid`.
